pwm_shadow_multichannel: RTL and testbench

Next-generation multi-channel PWM generator. One shared prescaler and one shared period counter drive NPWM compare channels. Adds double-buffered (shadow) duty registers committed only at period boundaries, an edge- or center-aligned counter mode, and per-channel enables. Sits between the control/register logic and the actuator pins (servo/LED/motor drivers).

---
 rtl/pwm_shadow_multichannel.sv | 161 ++++++++++++++++
 tb/tb_pwm_shadow_multichannel.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_shadow_multichannel.sv
// Multi-channel PWM generator with a shared prescaler and period counter.
// Duty values are double-buffered: DC_load fills a shadow copy that is only
// committed to the compare registers on a period boundary, so a running period
// never sees a torn duty update. Edge- or center-aligned counting is selected
// per period, and channel enables take effect at the boundary (turn-off is
// immediate).
module pwm_shadow_multichannel #(
    parameter int SysClk     = 125000000,
    parameter int PWMFreq    = 50,
    parameter int NPWM       = 5,
    parameter int Resolution = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 FreqSel,
    input  logic                       Mode,
    input  logic [NPWM*Resolution-1:0] DC_bus,
    input  logic                       DC_load,
    input  logic [NPWM-1:0]            Ch_en,
    output logic [NPWM-1:0]            PWMOut,
    output logic                       PeriodStart,
    output logic                       UpdPending
);

    localparam int R       = Resolution;
    localparam int TICKDIV = SysClk / (PWMFreq * (2 ** R));
    localparam int DW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;

    localparam logic [R-1:0] CNT_MAX  = '1;
    localparam logic [R-1:0] CNT_ONE  = R'(1);
    localparam logic [R-1:0] CNT_ZERO = '0;
    localparam logic         DIR_UP   = 1'b1;
    localparam logic         DIR_DOWN = 1'b0;

    // Shared timebase state
    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] div_last;
    logic [31:0]   div_shift;
    logic          tick;

    logic [R-1:0]  cnt_q, cnt_d, cnt_step;
    logic          dir_q, dir_d, dir_step;
    logic          mode_q, mode_d;
    logic          boundary;

    logic          pending_q, pending_d;
    logic          pstart_q;

    // Terminal divider value: TICKDIV scaled down by the frequency multiplier,
    // never allowed below a divide-by-one.
    always_comb begin
        div_shift = 32'(TICKDIV) >> FreqSel;
        if (div_shift <= 32'd1) begin
            div_last = '0;
        end else begin
            div_last = DW'(div_shift - 32'd1);
        end
    end

    // Divider reaching (or overshooting after a FreqSel change) its terminal value is a tick
    always_comb begin
        tick  = (div_q >= div_last);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Counter step: saw-tooth in edge mode, triangle in center mode
    always_comb begin
        cnt_step = cnt_q;
        dir_step = dir_q;
        if (!mode_q) begin
            cnt_step = cnt_q + CNT_ONE;
            dir_step = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == CNT_MAX) begin
                cnt_step = CNT_MAX - CNT_ONE;
                dir_step = DIR_DOWN;
            end else begin
                cnt_step = cnt_q + CNT_ONE;
                dir_step = DIR_UP;
            end
        end else begin
            cnt_step = cnt_q - CNT_ONE;
            dir_step = (cnt_q == CNT_ONE) ? DIR_UP : DIR_DOWN;
        end
    end

    // Boundary handling: a boundary always restarts at 0 counting up, which
    // also covers the restart required when the mode changes.
    always_comb begin
        boundary  = tick && (cnt_step == CNT_ZERO);
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        if (boundary) begin
            cnt_d  = CNT_ZERO;
            dir_d  = DIR_UP;
            mode_d = Mode;
        end else if (tick) begin
            cnt_d  = cnt_step;
            dir_d  = dir_step;
        end
        // A load wins over the boundary clear so a coincident load stays pending
        pending_d = DC_load | (pending_q & ~boundary);
    end

    // Shared timebase and update-tracking registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= '0;
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= 1'b0;
            pending_q <= 1'b0;
            pstart_q  <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            pstart_q  <= boundary;
        end
    end

    assign PeriodStart = pstart_q;
    assign UpdPending  = pending_q;

    // Per-channel shadow/active duty, enable and compare output
    for (genvar gi = 0; gi < NPWM; gi++) begin : g_ch
        logic [R-1:0] shadow_q, shadow_d;
        logic [R-1:0] active_q, active_d;
        logic         en_q, en_d;
        logic         pwm_q, pwm_d;

        // Next-state for this channel: commit at boundary, disable immediately
        always_comb begin
            shadow_d = DC_load ? DC_bus[gi*R +: R] : shadow_q;
            active_d = (boundary && pending_q) ? shadow_q : active_q;
            en_d     = boundary ? Ch_en[gi] : (en_q & Ch_en[gi]);
            pwm_d    = en_q & (active_q > cnt_q);
        end

        // Channel registers
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                shadow_q <= '0;
                active_q <= '0;
                en_q     <= 1'b0;
                pwm_q    <= 1'b0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
                en_q     <= en_d;
                pwm_q    <= pwm_d;
            end
        end

        assign PWMOut[gi] = pwm_q;
    end

endmodule

// File: tb/tb_pwm_shadow_multichannel.sv
// Bench for pwm_shadow_multichannel: directed scenarios followed by random
// segments, every cycle compared against a position-in-period reference model.
module tb_pwm_shadow_multichannel;

    localparam int NPWM    = 2;
    localparam int R       = 4;
    localparam int MAXV    = 15;
    localparam int TICKDIV = 1600 / (25 * 16);

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [1:0]           FreqSel = 2'd0;
    logic                 Mode = 1'b0;
    logic [NPWM*R-1:0]    DC_bus = '0;
    logic                 DC_load = 1'b0;
    logic [NPWM-1:0]      Ch_en = '0;
    logic [NPWM-1:0]      PWMOut;
    logic                 PeriodStart;
    logic                 UpdPending;

    int tests_run = 0;
    int fail_cnt  = 0;

    pwm_shadow_multichannel #(
        .SysClk(1600), .PWMFreq(25), .NPWM(NPWM), .Resolution(R)
    ) dut (
        .clk(clk), .reset(reset), .FreqSel(FreqSel), .Mode(Mode),
        .DC_bus(DC_bus), .DC_load(DC_load), .Ch_en(Ch_en),
        .PWMOut(PWMOut), .PeriodStart(PeriodStart), .UpdPending(UpdPending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // State is the divider phase and the tick position inside the period; the
    // counter value is derived from the position with plain arithmetic.
    int        m_div, m_pos;
    bit        m_mode, m_pend, m_ps;
    int        m_shadow [NPWM];
    int        m_active [NPWM];
    bit [NPWM-1:0] m_en, m_out;

    function automatic int period_ticks(bit md);
        return md ? 2 * MAXV : MAXV + 1;
    endfunction

    function automatic int cnt_at(int pos, bit md);
        return (!md || pos <= MAXV) ? pos : 2 * MAXV - pos;
    endfunction

    function automatic int div_last_of(int fs);
        int d = TICKDIV >> fs;
        if (d < 1) d = 1;
        return d - 1;
    endfunction

    function automatic bit boundary_next();
        return (m_div >= div_last_of(int'(FreqSel))) && (m_pos == period_ticks(m_mode) - 1);
    endfunction

    task automatic model_reset();
        m_div = 0; m_pos = 0; m_mode = 0; m_pend = 0; m_ps = 0;
        m_en = '0; m_out = '0;
        for (int i = 0; i < NPWM; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    endtask

    task automatic model_clock();
        bit tick, bnd;
        int c;
        tick = (m_div >= div_last_of(int'(FreqSel)));
        c    = cnt_at(m_pos, m_mode);
        bnd  = tick && (m_pos == period_ticks(m_mode) - 1);
        for (int i = 0; i < NPWM; i++) m_out[i] = m_en[i] && (m_active[i] > c);
        m_ps  = bnd;
        m_div = tick ? 0 : m_div + 1;
        if (tick) m_pos = bnd ? 0 : m_pos + 1;
        if (bnd) m_mode = Mode;
        if (bnd && m_pend) for (int i = 0; i < NPWM; i++) m_active[i] = m_shadow[i];
        m_en   = bnd ? Ch_en : (m_en & Ch_en);
        m_pend = DC_load ? 1'b1 : (bnd ? 1'b0 : m_pend);
        if (DC_load) for (int i = 0; i < NPWM; i++) m_shadow[i] = int'(DC_bus[i*R +: R]);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge
    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_clock();
        @(negedge clk);
        check("pwm", 32'(PWMOut), 32'(m_out));
        check("pstart", 32'(PeriodStart), 32'(m_ps));
        check("pending", 32'(UpdPending), 32'(m_pend));
    endtask

    task automatic load(input logic [R-1:0] d1, input logic [R-1:0] d0);
        DC_bus  = {d1, d0};
        DC_load = 1'b1;
        step();
        DC_load = 1'b0;
    endtask

    task automatic wait_ps();
        int n = 0;
        do begin
            step();
            n++;
        end while (!PeriodStart && n < 400);
        if (!PeriodStart) check("ps_timeout", 32'(PeriodStart), 32'd1);
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step();
            hi += int'(PWMOut[ch]);
        end
    endtask

    task automatic measure_period(output int len);
        wait_ps();
        len = 0;
        do begin
            step();
            len++;
        end while (!PeriodStart && len < 400);
    endtask

    initial begin
        int hi, len, n;
        model_reset();

        // Reset state
        repeat (3) step();
        check("rst_pwm", 32'(PWMOut), 32'd0);
        check("rst_ps", 32'(PeriodStart), 32'd0);
        check("rst_pend", 32'(UpdPending), 32'd0);
        reset = 1'b1;
        $display("[TB] reset released");

        // Edge mode, duty 4: 16 of 64 clk high, duty-0 channel silent
        Mode = 1'b0; FreqSel = 2'd0; Ch_en = 2'b11;
        load(4'd0, 4'd4);
        wait_ps();
        count_high(0, 64, hi);
        check("edge_d4_high", 32'(hi), 32'd16);
        count_high(1, 64, hi);
        check("edge_d0_high", 32'(hi), 32'd0);
        $display("[TB] edge duty 4 period checked");

        // Shadow update mid-period, committed at the next boundary
        wait_ps();
        repeat (10) step();
        load(4'd0, 4'd12);
        check("shadow_pend", 32'(UpdPending), 32'd1);
        wait_ps();
        count_high(0, 64, hi);
        check("shadow_high", 32'(hi), 32'd48);
        check("shadow_clear", 32'(UpdPending), 32'd0);
        $display("[TB] shadow update to 12 checked");

        // Load coincident with the boundary tick stays pending
        n = 0;
        while (!boundary_next() && n < 400) begin
            step();
            n++;
        end
        load(4'd0, 4'd6);
        check("coinc_ps", 32'(PeriodStart), 32'd1);
        check("coinc_pend", 32'(UpdPending), 32'd1);
        $display("[TB] coincident load checked");

        // Center mode, duty 8: 120 clk period, 60 clk high
        repeat (7) step();
        Mode = 1'b1;
        load(4'd0, 4'd8);
        wait_ps();
        count_high(0, 120, hi);
        check("center_high", 32'(hi), 32'd60);
        measure_period(len);
        check("center_period", 32'(len), 32'd120);
        $display("[TB] center mode checked");

        // Frequency select
        Mode = 1'b0; FreqSel = 2'd2;
        measure_period(len);
        measure_period(len);
        check("fs2_period", 32'(len), 32'd16);
        FreqSel = 2'd3;
        measure_period(len);
        check("fs3_period", 32'(len), 32'd16);
        FreqSel = 2'd1;
        measure_period(len);
        check("fs1_period", 32'(len), 32'd32);
        $display("[TB] frequency select checked");

        // Enable control
        FreqSel = 2'd0;
        load(4'd0, 4'd8);
        wait_ps();
        n = 0;
        while (!PWMOut[0] && n < 200) begin
            step();
            n++;
        end
        check("en_was_high", 32'(PWMOut[0]), 32'd1);
        Ch_en = 2'b10;
        step();
        step();
        check("en_drop", 32'(PWMOut[0]), 32'd0);
        repeat (5) step();
        Ch_en = 2'b11;
        hi = 0;
        n = 0;
        do begin
            step();
            hi += int'(PWMOut[0]);
            n++;
        end while (!PeriodStart && n < 400);
        check("en_wait_bnd", 32'(hi), 32'd0);
        count_high(0, 64, hi);
        check("en_resumed", 32'(hi), 32'd32);
        $display("[TB] enable control checked");

        // Asynchronous reset mid-period with a pending update
        repeat (9) step();
        load(4'd3, 4'd5);
        check("rst_pre_pend", 32'(UpdPending), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_pwm", 32'(PWMOut), 32'd0);
        check("arst_pend", 32'(UpdPending), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        count_high(0, 150, hi);
        check("post_rst_ch0", 32'(hi), 32'd0);
        count_high(1, 70, hi);
        check("post_rst_ch1", 32'(hi), 32'd0);
        $display("[TB] mid-period reset checked");

        // Random segments
        for (int s = 0; s < 150; s++) begin
            FreqSel = 2'($urandom_range(0, 3));
            Mode    = 1'($urandom_range(0, 1));
            len     = int'($urandom_range(20, 250));
            for (int k = 0; k < len; k++) begin
                DC_load = ($urandom_range(0, 24) == 0);
                DC_bus  = (NPWM*R)'($urandom);
                if ($urandom_range(0, 39) == 0) Ch_en = NPWM'($urandom);
                step();
            end
            DC_load = 1'b0;
            $display("[TB] random segment %0d: FreqSel=%0d Mode=%0d cycles=%0d", s, FreqSel, Mode, len);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
